// File: rtl/mic_array_capture.sv
// mic_array_capture: multi-line I2S microphone array front end.
// Generates SCK/WS, captures left/right slots per data line and streams
// sign-extended samples through a frame-atomic FIFO.
// Ports: clk_i/rst_i clock and async reset, en_i enable, chan_mask_i
// channel mask, sck_o/ws_o/sd_i I2S pins, m_* valid/ready sample stream,
// ovf_pulse_o/ovf_cnt_o/clr_ovf_i dropped-frame accounting.
module mic_array_capture #(
    parameter int NUM_LINES      = 4,
    parameter int SAMPLE_WIDTH   = 24,
    parameter int SLOT_BITS      = 32,
    parameter int OUT_WIDTH      = 32,
    parameter int CLK_DIV        = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int DISCARD_FRAMES = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             en_i,
    input  logic [2*NUM_LINES-1:0]           chan_mask_i,
    output logic                             sck_o,
    output logic                             ws_o,
    input  logic [NUM_LINES-1:0]             sd_i,
    output logic [OUT_WIDTH-1:0]             m_data_o,
    output logic [$clog2(2*NUM_LINES)-1:0]   m_chan_o,
    output logic                             m_last_o,
    output logic                             m_valid_o,
    input  logic                             m_ready_i,
    output logic                             ovf_pulse_o,
    output logic [15:0]                      ovf_cnt_o,
    input  logic                             clr_ovf_i
);
    localparam int NCH = 2*NUM_LINES;
    localparam int CW  = $clog2(NCH);
    localparam int DW  = $clog2(CLK_DIV);
    localparam int BW  = $clog2(2*SLOT_BITS);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int DCW = $clog2(DISCARD_FRAMES+2);
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_PUSH = 1'b1;

    logic [DW-1:0]           div_q;
    logic                    sck_q, ws_q;
    logic [BW-1:0]           bit_q, bit_d, slot_b;
    logic                    tc, rise, fall, slot, in_win, fend;
    logic [NUM_LINES-1:0]    s1_q, s2_q;
    logic [SAMPLE_WIDTH-1:0] sh_q [NCH];
    logic [SAMPLE_WIDTH-1:0] sd_q [NCH];
    logic [DCW-1:0]          disc_q;
    logic                    state_q;
    logic [NCH-1:0]          pend_q, pend_d;
    logic [CW-1:0]           idx;
    logic                    push, push_last, accept, drop;
    int                      k_w, free_w;
    logic [AW:0]             wp_q, rp_q, cnt_w;
    logic [SAMPLE_WIDTH-1:0] fd_mem [FIFO_DEPTH];
    logic [CW-1:0]           fc_mem [FIFO_DEPTH];
    logic                    fl_mem [FIFO_DEPTH];
    logic [SAMPLE_WIDTH-1:0] rd_s;
    logic                    pop, ovf_pulse_q;
    logic [15:0]             ovf_cnt_q;

    assign tc     = div_q == DW'(CLK_DIV-1);
    assign rise   = en_i && tc && !sck_q;
    assign fall   = en_i && tc && sck_q;
    assign bit_d  = (bit_q == BW'(2*SLOT_BITS-1)) ? '0 : bit_q + BW'(1);
    assign slot   = bit_q >= BW'(SLOT_BITS);
    assign slot_b = slot ? bit_q - BW'(SLOT_BITS) : bit_q;
    assign in_win = (slot_b != '0) && (slot_b <= BW'(SAMPLE_WIDTH));
    assign fend   = rise && (bit_q == BW'(2*SLOT_BITS-1));

    // SCK divider, bit counter and WS; WS only moves on SCK fall events.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q <= '0;
            sck_q <= 1'b0;
            bit_q <= '0;
            ws_q  <= 1'b0;
        end else if (!en_i) begin
            div_q <= '0;
            sck_q <= 1'b0;
            bit_q <= '0;
            ws_q  <= 1'b0;
        end else begin
            div_q <= tc ? '0 : div_q + DW'(1);
            if (tc) sck_q <= !sck_q;
            if (fall) begin
                bit_q <= bit_d;
                ws_q  <= bit_d >= BW'(SLOT_BITS);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= sd_i;
            s2_q <= s1_q;
        end
    end

    // Shift registers indexed by channel = 2*line + slot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < NCH; c++) sh_q[c] <= '0;
        end else if (!en_i) begin
            for (int c = 0; c < NCH; c++) sh_q[c] <= '0;
        end else if (rise && in_win) begin
            for (int l = 0; l < NUM_LINES; l++)
                sh_q[2*l+int'(slot)] <=
                    {sh_q[2*l+int'(slot)][SAMPLE_WIDTH-2:0], s2_q[l]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < NCH; c++) sd_q[c] <= '0;
        end else if (fend) begin
            for (int c = 0; c < NCH; c++) sd_q[c] <= sh_q[c];
        end
    end

    // Frame disposition; free space uses occupancy before any same-cycle pop.
    always_comb begin
        k_w = 0;
        for (int c = 0; c < NCH; c++) k_w = k_w + int'(chan_mask_i[c]);
    end
    assign cnt_w  = wp_q - rp_q;
    assign free_w = FIFO_DEPTH - int'(cnt_w);
    assign accept = fend && disc_q == '0 && k_w != 0 && free_w >= k_w;
    assign drop   = fend && disc_q == '0 && k_w != 0 && free_w < k_w;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                      disc_q <= DCW'(DISCARD_FRAMES);
        else if (!en_i)                 disc_q <= DCW'(DISCARD_FRAMES);
        else if (fend && disc_q != '0)  disc_q <= disc_q - DCW'(1);
    end

    // Serializer: lowest pending channel first, one push per clock.
    always_comb begin
        idx = '0;
        for (int c = NCH-1; c >= 0; c--)
            if (pend_q[c]) idx = CW'(c);
    end
    assign pend_d    = pend_q & ~(NCH'(1) << idx);
    assign push      = state_q == ST_PUSH;
    assign push_last = pend_d == '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
        end else if (state_q == ST_IDLE) begin
            if (accept) begin
                state_q <= ST_PUSH;
                pend_q  <= chan_mask_i;
            end
        end else begin
            pend_q <= pend_d;
            if (push_last) state_q <= ST_IDLE;
        end
    end

    assign pop = m_valid_o && m_ready_i;

    always_ff @(posedge clk_i) begin
        if (push) begin
            fd_mem[wp_q[AW-1:0]] <= sd_q[idx];
            fc_mem[wp_q[AW-1:0]] <= idx;
            fl_mem[wp_q[AW-1:0]] <= push_last;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (push) wp_q <= wp_q + (AW+1)'(1);
            if (pop)  rp_q <= rp_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_pulse_q <= 1'b0;
            ovf_cnt_q   <= '0;
        end else begin
            ovf_pulse_q <= drop;
            if (clr_ovf_i)
                ovf_cnt_q <= '0;
            else if (drop && ovf_cnt_q != 16'hFFFF)
                ovf_cnt_q <= ovf_cnt_q + 16'd1;
        end
    end

    assign rd_s        = fd_mem[rp_q[AW-1:0]];
    assign m_valid_o   = wp_q != rp_q;
    assign m_data_o    = m_valid_o ? OUT_WIDTH'($signed(rd_s)) : '0;
    assign m_chan_o    = m_valid_o ? fc_mem[rp_q[AW-1:0]] : '0;
    assign m_last_o    = m_valid_o && fl_mem[rp_q[AW-1:0]];
    assign sck_o       = sck_q;
    assign ws_o        = ws_q;
    assign ovf_pulse_o = ovf_pulse_q;
    assign ovf_cnt_o   = ovf_cnt_q;
endmodule

// File: tb/tb_mic_array_capture.sv
// tb_mic_array_capture: directed bench for mic_array_capture.
// I2S BFM per line plus linear directed checks with immediate assertions.
module tb_mic_array_capture;
    localparam int CLK_DIV = 8;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        en_i = 1'b0;
    logic [7:0]  chan_mask_i = 8'h00;
    logic        sck_o, ws_o;
    logic [3:0]  sd_i = 4'h0;
    logic [31:0] m_data_o;
    logic [2:0]  m_chan_o;
    logic        m_last_o, m_valid_o;
    logic        m_ready_i = 1'b0;
    logic        ovf_pulse_o;
    logic [15:0] ovf_cnt_o;
    logic        clr_ovf_i = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    logic [23:0] chv [8];

    mic_array_capture dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i),
        .chan_mask_i(chan_mask_i), .sck_o(sck_o), .ws_o(ws_o),
        .sd_i(sd_i), .m_data_o(m_data_o), .m_chan_o(m_chan_o),
        .m_last_o(m_last_o), .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i), .ovf_pulse_o(ovf_pulse_o),
        .ovf_cnt_o(ovf_cnt_o), .clr_ovf_i(clr_ovf_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // I2S microphones: data changes after SCK falls, bit n of the frame.
    initial begin
        int bcnt;
        logic en_prev;
        bcnt = 0;
        en_prev = 1'b0;
        forever begin
            @(negedge sck_o or en_i);
            if (en_i != en_prev || !en_i) bcnt = 0;
            else bcnt = (bcnt + 1) % 64;
            en_prev = en_i;
            for (int l = 0; l < 4; l++) begin
                logic [23:0] v;
                int b;
                v = chv[2*l + bcnt/32];
                b = bcnt % 32;
                sd_i[l] = (b >= 1 && b <= 24) ? v[24-b] : 1'b0;
            end
        end
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp,
                       input string tag);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_vals(input logic [23:0] base);
        for (int c = 0; c < 8; c++) chv[c] = base + 24'(c);
    endtask

    task automatic wait_valid(input int lim, output int n);
        n = 0;
        while (!m_valid_o && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic expect_word(input logic [31:0] d, input int c,
                               input logic l, input int maxstall,
                               input string tag);
        int n;
        int st;
        wait_valid(5000, n);
        chk(32'(m_valid_o), 32'd1, {tag, "_valid"});
        st = (maxstall > 0) ? int'($urandom_range(maxstall, 0)) : 0;
        repeat (st) @(negedge clk);
        chk(m_data_o, d, {tag, "_data"});
        chk(32'(m_chan_o), 32'(c), {tag, "_chan"});
        chk(32'(m_last_o), 32'(l), {tag, "_last"});
        m_ready_i = 1'b1;
        @(negedge clk);
        m_ready_i = 1'b0;
    endtask

    initial begin
        int n;
        int c0;
        int t1;
        logic saw_v;
        logic saw_p;
        set_vals(24'h0);

        // Reset values
        repeat (3) @(negedge clk);
        chk(32'({sck_o, ws_o, m_valid_o, m_last_o, ovf_pulse_o}), 32'd0,
            "rst_flags");
        chk(m_data_o, 32'd0, "rst_data");
        chk(32'(m_chan_o), 32'd0, "rst_chan");
        chk(32'(ovf_cnt_o), 32'd0, "rst_ovf_cnt");
        rst_i = 1'b0;
        @(negedge clk);

        // Single channel with sign extension, discard and clock timing
        chan_mask_i = 8'h03;
        chv[0] = 24'h800001;
        chv[1] = 24'h7FFFFF;
        en_i = 1'b1;
        c0 = cyc;
        n = 0;
        while (!sck_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(32'(n), 32'(CLK_DIV), "sck_first_rise");
        n = 0;
        while (!ws_o && n < 2000) begin @(negedge clk); n++; end
        t1 = cyc;
        n = 0;
        while (ws_o && n < 2000) begin @(negedge clk); n++; end
        n = 0;
        while (!ws_o && n < 2000) begin @(negedge clk); n++; end
        chk(32'(cyc - t1), 32'(128*CLK_DIV), "ws_period");
        wait_valid(5000, n);
        chk(32'(cyc - c0), 32'd3065, "single_first_valid");
        expect_word(32'hFF800001, 0, 1'b0, 0, "single_l");
        expect_word(32'h007FFFFF, 1, 1'b1, 0, "single_r");
        en_i = 1'b0;
        repeat (4) @(negedge clk);

        // Full array with random back-pressure
        set_vals(24'h100000);
        chan_mask_i = 8'hFF;
        en_i = 1'b1;
        for (int f = 0; f < 20; f++)
            for (int c = 0; c < 8; c++)
                expect_word(32'h00100000 + 32'(c), c, c == 7, 3,
                            $sformatf("full_f%0d_c%0d", f, c));
        chk(32'(ovf_cnt_o), 32'd0, "full_no_ovf");
        en_i = 1'b0;
        repeat (4) @(negedge clk);
        chk(32'(m_valid_o), 32'd0, "full_drained");

        // Overflow: two frames fill the FIFO, third is dropped whole
        set_vals(24'h200000);
        en_i = 1'b1;
        c0 = cyc;
        n = 0;
        while (!ovf_pulse_o && n < 7000) begin @(negedge clk); n++; end
        chk(32'(cyc - c0), 32'd5112, "ovf_pulse_time");
        chk(32'(ovf_cnt_o), 32'd1, "ovf_cnt_one");
        @(negedge clk);
        chk(32'(ovf_pulse_o), 32'd0, "ovf_pulse_width");
        en_i = 1'b0;
        for (int k = 0; k < 16; k++)
            expect_word(32'h00200000 + 32'(k % 8), k % 8, (k % 8) == 7, 0,
                        $sformatf("ovf_w%0d", k));
        chk(32'(m_valid_o), 32'd0, "ovf_exact16");
        clr_ovf_i = 1'b1;
        @(negedge clk);
        clr_ovf_i = 1'b0;
        chk(32'(ovf_cnt_o), 32'd0, "ovf_clear");

        // Mask change after frame end, then empty mask
        set_vals(24'h300000);
        chan_mask_i = 8'hFF;
        en_i = 1'b1;
        wait_valid(5000, n);
        chan_mask_i = 8'h05;
        for (int c = 0; c < 8; c++)
            expect_word(32'h00300000 + 32'(c), c, c == 7, 0,
                        $sformatf("mask_a_c%0d", c));
        expect_word(32'h00300000, 0, 1'b0, 0, "mask_b_c0");
        expect_word(32'h00300002, 2, 1'b1, 0, "mask_b_c2");
        chan_mask_i = 8'h00;
        saw_v = 1'b0;
        saw_p = 1'b0;
        repeat (1200) begin
            @(negedge clk);
            if (m_valid_o) saw_v = 1'b1;
            if (ovf_pulse_o) saw_p = 1'b1;
        end
        chk(32'(saw_v), 32'd0, "mask0_no_push");
        chk(32'(saw_p), 32'd0, "mask0_no_ovf");
        chk(32'(ovf_cnt_o), 32'd0, "mask0_cnt");
        en_i = 1'b0;
        chan_mask_i = 8'hFF;
        @(negedge clk);

        // Disable at bit 40 of frame 4 with one frame queued
        set_vals(24'h400000);
        en_i = 1'b1;
        c0 = cyc;
        while (cyc - c0 < 3712) @(negedge clk);
        chk(32'(ws_o), 32'd1, "dis_ws_pre");
        en_i = 1'b0;
        @(negedge clk);
        chk(32'({sck_o, ws_o}), 32'd0, "dis_pins_low");
        for (int c = 0; c < 8; c++)
            expect_word(32'h00400000 + 32'(c), c, c == 7, 0,
                        $sformatf("dis_q_c%0d", c));
        saw_v = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (m_valid_o) saw_v = 1'b1;
        end
        chk(32'(saw_v), 32'd0, "dis_partial_lost");
        set_vals(24'h500000);
        en_i = 1'b1;
        c0 = cyc;
        wait_valid(5000, n);
        chk(32'(cyc - c0), 32'd3065, "reen_first_valid");
        expect_word(32'h00500000, 0, 1'b0, 0, "reen_c0");
        chk(32'(m_valid_o), 32'd1, "reen_more_queued");

        // Asynchronous reset during traffic
        rst_i = 1'b1;
        #1;
        chk(32'({sck_o, ws_o, m_valid_o, m_last_o, ovf_pulse_o}), 32'd0,
            "arst_flags");
        chk(m_data_o, 32'd0, "arst_data");
        @(negedge clk);
        en_i = 1'b0;
        rst_i = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
